// File: rtl/arm_cond_unit.sv
// ARM multicycle condition unit: NZCV flags register, latched condition result, and write-strobe gating.
// Optional squash counter enabled by defining COND_SQUASH_CNT_EN; otherwise SquashCount is tied to zero.
module arm_cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CondLatch,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SquashCount
);

  typedef enum logic {
    HOLD_FAIL = 1'b0,
    HOLD_PASS = 1'b1
  } hold_e;

  hold_e      state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_now;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Evaluated against the registered flags only, so a same-cycle update never feeds back.
  always_comb begin
    cond_now = 1'b0;
    unique case (Cond)
      4'b0000: cond_now = z_f;
      4'b0001: cond_now = ~z_f;
      4'b0010: cond_now = c_f;
      4'b0011: cond_now = ~c_f;
      4'b0100: cond_now = n_f;
      4'b0101: cond_now = ~n_f;
      4'b0110: cond_now = v_f;
      4'b0111: cond_now = ~v_f;
      4'b1000: cond_now = c_f & ~z_f;
      4'b1001: cond_now = ~c_f | z_f;
      4'b1010: cond_now = (n_f == v_f);
      4'b1011: cond_now = (n_f != v_f);
      4'b1100: cond_now = ~z_f & (n_f == v_f);
      4'b1101: cond_now = z_f | (n_f != v_f);
      default: cond_now = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (CondLatch) begin
      state_d = cond_now ? HOLD_PASS : HOLD_FAIL;
    end
  end

  always_comb begin
    CondEx = 1'b0;
    if (reset) begin
      CondEx = CondLatch ? cond_now : (state_q == HOLD_PASS);
    end
  end

  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;
  assign Flags    = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (CondEx) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD_FAIL;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CondLatch && !cond_now && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign SquashCount = cnt_q;
`else
  assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_arm_cond_unit.sv
// Self-checking bench for arm_cond_unit: reference model compared every cycle plus directed literal checks.
module tb_arm_cond_unit;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             CondLatch;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite;
  logic             PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SquashCount;

  int errors = 0;
  int checks = 0;

  arm_cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .CondLatch(CondLatch), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
    .SquashCount(SquashCount)
  );

`ifdef COND_SQUASH_CNT_EN
  logic       p2, r2, m2, c2;
  logic [3:0] f2;
  logic [1:0] sc2;
  arm_cond_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .CondLatch(CondLatch), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .PCSrc(p2), .RegWrite(r2),
    .MemWrite(m2), .CondEx(c2), .Flags(f2), .SquashCount(sc2)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: conditions come in complementary pairs; odd codes invert the even base.
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b1;
    return base ^ c[0];
  endfunction

  logic [3:0] m_flags = '0;
  bit         m_hold  = 1'b0;
  int         m_cnt   = 0;

  function automatic bit model_condex();
    if (!reset) return 1'b0;
    return CondLatch ? model_cond(Cond, m_flags) : m_hold;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flags = '0;
      m_hold  = 1'b0;
      m_cnt   = 0;
    end else begin
      bit ex, now;
      now = model_cond(Cond, m_flags);
      ex  = CondLatch ? now : m_hold;
      if (CondLatch && !now && m_cnt < (2**CNT_W - 1)) m_cnt = m_cnt + 1;
      if (CondLatch) m_hold = now;
      if (ex && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (ex && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
    end
  end

  always @(negedge clk) begin
    bit ex;
    int exp_cnt;
    ex = model_condex();
`ifdef COND_SQUASH_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("CondEx",      int'(CondEx),      int'(ex));
    chk("PCSrc",       int'(PCSrc),       int'(PCS & ex));
    chk("RegWrite",    int'(RegWrite),    int'(RegW & ex & !NoWrite));
    chk("MemWrite",    int'(MemWrite),    int'(MemW & ex));
    chk("Flags",       int'(Flags),       int'(m_flags));
    chk("SquashCount", int'(SquashCount), exp_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    CondLatch = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
    step();
    CondLatch = 1'b0; FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b0; CondLatch = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    step(); step();
    chk("rst_Flags", int'(Flags), 0);
    chk("rst_PCSrc", int'(PCSrc), 0);
    chk("rst_RegWrite", int'(RegWrite), 0);
    chk("rst_MemWrite", int'(MemWrite), 0);
    chk("rst_CondEx", int'(CondEx), 0);

    reset = 1'b1; CondLatch = 1'b0; FlagW = 2'b00;
    #1 chk("post_rst_RegWrite", int'(RegWrite), 0);
    step();
    chk("post_rst_CondEx", int'(CondEx), 0);
    chk("post_rst_Flags", int'(Flags), 0);

    CondLatch = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b10;
    step();
    CondLatch = 1'b0; FlagW = 2'b00;
    chk("split_nz", int'(Flags), 4'b1100);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    step();
    FlagW = 2'b00;
    chk("split_cv", int'(Flags), 4'b1111);

    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        CondLatch = 1'b1; Cond = 4'(c);
        #1;
        if (f == 9 && c == 10) chk("GE_1001", int'(CondEx), 1);
        if (f == 9 && c == 12) chk("GT_1001", int'(CondEx), 1);
        if (f == 4 && c == 12) chk("GT_0100", int'(CondEx), 0);
        step();
      end
      CondLatch = 1'b0;
    end

    load_flags(4'h0);
    CondLatch = 1'b1; Cond = 4'h0; RegW = 1'b1; MemW = 1'b1;
    step();
    CondLatch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_RegWrite", int'(RegWrite), 0);
      chk("hold_MemWrite", int'(MemWrite), 0);
      step();
    end
    CondLatch = 1'b1; Cond = 4'h1;
    #1 chk("ne_RegWrite", int'(RegWrite), 1);
    step();
    CondLatch = 1'b0; RegW = 1'b0;
    #1 chk("follow_RegW0", int'(RegWrite), 0);
    RegW = 1'b1;
    #1 chk("follow_RegW1", int'(RegWrite), 1);
    step();
    RegW = 1'b0; MemW = 1'b0;

    load_flags(4'b0100);
    Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b1000; CondLatch = 1'b1;
    #1 chk("sq_CondEx", int'(CondEx), 0);
    step();
    FlagW = 2'b00; CondLatch = 1'b0;
    chk("sq_Flags", int'(Flags), 4'b0100);
    Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b1000; CondLatch = 1'b1;
    #1 chk("eq_CondEx", int'(CondEx), 1);
    step();
    FlagW = 2'b00; CondLatch = 1'b0;
    chk("eq_Flags", int'(Flags), 4'b1000);
    Cond = 4'hE; CondLatch = 1'b1; NoWrite = 1'b1; RegW = 1'b1;
    #1 chk("cmp_RegWrite", int'(RegWrite), 0);
    step();
    CondLatch = 1'b0; NoWrite = 1'b0; RegW = 1'b0;

    reset = 1'b0;
    step();
    reset = 1'b1;
    Cond = 4'h0;
    for (int i = 0; i < 5; i++) begin
      CondLatch = 1'b1;
      step();
    end
    CondLatch = 1'b0;
`ifdef COND_SQUASH_CNT_EN
    chk("squash5", int'(SquashCount), 5);
`else
    chk("squash_off", int'(SquashCount), 0);
`endif
    CondLatch = 1'b1;
    step();
    CondLatch = 1'b0;
`ifdef COND_SQUASH_CNT_EN
    chk("squash6", int'(SquashCount), 6);
    chk("squash_sat", int'(sc2), 3);
`else
    chk("squash_off6", int'(SquashCount), 0);
`endif
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arm_cond_unit.md
Name: arm_cond_unit

Overview:
- Condition unit for the multicycle ARM datapath; it consumes the 4-bit NZCV flags produced by the ALU.
- Holds the architectural flags register with split NZ/CV write enables.
- Evaluates the 4-bit instruction condition field once per instruction and holds that result for the remaining instruction cycles.
- Gates the decoder's PCS/RegW/MemW strobes into the datapath's PCSrc/RegWrite/MemWrite.

Parameters:
- CNT_W, 16, width of the squash counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- CondLatch  input  1  one-cycle pulse on an instruction's first execute cycle; evaluates Cond against the current flags and latches the result.
- Cond  input  4  instruction bits [31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU: [3]=N, [2]=Z, [1]=C, [0]=V.
- FlagW  input  2  [1] = update N,Z; [0] = update C,V.
- PCS  input  1  decoder PC-write request.
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  compare-type instruction; suppresses the register write.
- PCSrc  output  1  gated PC-write.
- RegWrite  output  1  gated register-write.
- MemWrite  output  1  gated memory-write.
- CondEx  output  1  effective condition result for the current cycle.
- Flags  output  4  current flags register {N,Z,C,V}.
- SquashCount  output  CNT_W  count of failed-condition instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - Flags=4'b0000, CondExR=0, SquashCount=0.
  - PCSrc, RegWrite, MemWrite and CondEx forced to 0 while reset is low, regardless of other inputs.
- Condition evaluation: combinational CondNow = f(Cond, Flags), using the registered Flags only, never ALUFlags.
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 treated as 1.
- Effective condition:
  - CondEx = CondLatch ? CondNow : CondExR.
  - On a clock edge with CondLatch=1, CondExR <= CondNow.
  - CondExR holds until the next CondLatch pulse; no timeout.
- Gated outputs (combinational, zero added latency):
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
  - MemWrite = MemW & CondEx.
- Flag update at the rising edge, only when CondEx=1:
  - FlagW[1] loads Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0] loads Flags[1:0] <= ALUFlags[1:0].
  - Both bits set means all four flags load; FlagW=00 leaves Flags unchanged.
  - New flags become visible on Flags and to CondNow the cycle after the edge.
- Simultaneous CondLatch and FlagW in the same cycle:
  - Evaluation uses the pre-update Flags.
  - The update is gated by CondNow of that same cycle.
- Conditional flag-setting instruction (e.g. ADDSEQ) whose condition fails: no flag field changes.
- Reset released mid-instruction: CondExR=0, so every strobe stays suppressed until the next CondLatch. This is intended; no instruction restarts without a CondLatch.
- State: single implicit two-state holder, HOLD_PASS (CondExR=1) / HOLD_FAIL (CondExR=0). Transitions occur only on CondLatch, going to HOLD_PASS if CondNow=1, else HOLD_FAIL.

Optional Feature:
- Macro: COND_SQUASH_CNT_EN.
- Defined:
  - SquashCount increments by 1 at each edge where CondLatch=1 and CondNow=0.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Undefined: the counter is not built and SquashCount is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset: hold reset=0, drive PCS=RegW=MemW=1, CondLatch=1, Cond=1110 -> Flags=0000, PCSrc=RegWrite=MemWrite=CondEx=0; after release with no CondLatch, outputs stay 0.
- Flag write split: ALUFlags=1111, FlagW=10, CondLatch=1, Cond=1110 -> next cycle Flags=1100; then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Condition table sweep: for each of 16 Flags values x 16 Cond codes pulse CondLatch -> CondEx matches the table, e.g. Flags=1001 (N=1, V=1), Cond=1010 GE -> 1; Cond=1100 GT -> 1; Flags=0100, Cond=1100 -> 0.
- Hold across cycles: Flags=0000, Cond=0000 EQ latched (fail), then 3 cycles with RegW=1, MemW=1, CondLatch=0 -> RegWrite=MemWrite=0 all cycles; next CondLatch with Cond=0001 -> RegWrite follows RegW.
- Squashed flag set and same-cycle ordering: Flags=0100, Cond=0001 NE, FlagW=11, ALUFlags=1000, CondLatch=1 -> CondEx=0, Flags stays 0100; repeat with Cond=0000 -> Flags becomes 1000 next cycle; CMP with NoWrite=1, RegW=1 -> RegWrite=0.
- COND_SQUASH_CNT_EN (defined): 5 failing CondLatch pulses -> SquashCount=5; with CNT_W=2 and 6 failing pulses -> saturates at 3; in an undefined build SquashCount=0 throughout.
